keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Drives the column strobes of a 4x4 matrix keypad, samples the row lines, debounces, and presents a stable one-hot `{row, col}` code for `keypad_decoder`. It sits between the keypad pins and the decoder. It owns every timing concern (scan rate, settling, bounce, release), so the decoder stays purely combinational.

## Interface
Parameters:
- `SCAN_DIV`, default 50000. Clock cycles per column slot; minimum 2.
- `DEBOUNCE_COUNT`, default 4. Consecutive slot samples required to accept a press or a release; minimum 1.

Ports:
- `clk`, input, 1. Single clock; every register is on its rising edge.
- `rst_n`, input, 1. Synchronous, active-low reset.
- `row_in`, input, 4. Raw keypad row lines, active-high, externally pulled low, asynchronous.
- `col_drive`, output, 4. One-hot active-high column strobe to the keypad.
- `row`, output, 4. Debounced one-hot row of the held key; 0 when no key is held.
- `col`, output, 4. Debounced one-hot column of the held key; 0 when no key is held.
- `key_pressed`, output, 1. Level signal, high while a debounced key is held.
- `key_strobe`, output, 1. One-cycle pulse when a new press is accepted.
- `release_strobe`, output, 1. One-cycle pulse when a release is accepted.

## Operation
- `row_in` passes through a 2-flop synchronizer. All logic below uses the synchronized value `row_s`.
- Slot divider: `div_cnt` counts from 0 to SCAN_DIV-1 and wraps. `tick` is asserted when `div_cnt` == SCAN_DIV-1. `row_s` is sampled only on `tick`, at the end of the slot, which allows settling time.
- State machine states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- **SCAN:** `col_drive` rotates on each `tick`, in the order 0001 → 0010 → 0100 → 1000 → 0001.
  - On a `tick` where `row_s` is exactly one-hot: capture `cand_row` = `row_s` and `cand_col` = `col_drive`, set `db_cnt` = 1, and freeze the column.
  - If DEBOUNCE_COUNT == 1, accept immediately and go to HELD. Otherwise go to PRESS_DB.
  - A zero sample keeps the scan running. So does a multi-hot sample (two keys in the same column), which is treated as no press.
- **PRESS_DB:** the column stays frozen.
  - On each `tick`, if `row_s` == `cand_row`, increment `db_cnt`. When `db_cnt` reaches DEBOUNCE_COUNT, accept and go to HELD.
  - On a mismatch, go to SCAN and advance to the next column. No output changes.
- **Accept press:** `row` = `cand_row`, `col` = `cand_col`, `key_pressed` = 1, and `key_strobe` pulses for one cycle.
- **HELD:** the column stays frozen.
  - On a `tick` where `row_s` != `cand_row` (zero, a different row, or multi-hot), set `db_cnt` = 1 and go to RELEASE_DB.
  - If DEBOUNCE_COUNT == 1, release immediately instead.
- **RELEASE_DB:**
  - On each `tick`, a non-matching sample increments `db_cnt`. When `db_cnt` reaches DEBOUNCE_COUNT, release.
  - A matching sample returns to HELD with no output change.
- **Release:** `row` = 0, `col` = 0, `key_pressed` = 0, and `release_strobe` pulses for one cycle. Then go to SCAN and advance to the next column.
- Keys pressed in other columns while a key is held are invisible, because the column is frozen. There is no rollover.
- `db_cnt` width is $clog2(DEBOUNCE_COUNT+1). `div_cnt` width is $clog2(SCAN_DIV).

## Timing
- **Reset values:** `col_drive` = 0001, `row` = 0, `col` = 0, `key_pressed` = 0, `key_strobe` = 0, `release_strobe` = 0. Internal state: state = SCAN, `div_cnt` = 0, `db_cnt` = 0, synchronizer flops = 0.
- **Reset mid-operation:** reset takes effect at the next clock edge from any state and behaves identically to power-up reset. No strobe is emitted on reset.
- All outputs are registered.
- **Strobe latency:** `key_strobe` and `release_strobe` are asserted in the cycle after the accepting `tick`. `row`, `col` and `key_pressed` update in that same cycle.
- **Press latency:** from the first matching `tick` to `key_strobe` is (DEBOUNCE_COUNT-1)·SCAN_DIV + 1 cycles. Input-to-`tick` delay adds 2 cycles for the synchronizer plus up to 4·SCAN_DIV for the scan position.
- `col_drive` changes in the cycle after a `tick` in SCAN, so it is stable for exactly SCAN_DIV cycles per slot.
- `key_strobe` and `release_strobe` are never asserted in the same cycle.
- At least one full slot separates a release from the next possible press strobe.

## Structure
- Package `keypad_pkg` holds:
  - the state enum `scan_state_t` (SCAN, PRESS_DB, HELD, RELEASE_DB);
  - column constants `COL0`..`COL3` (4'b0001..4'b1000);
  - the function `is_onehot4()`.
- Sub-module `keypad_sync`: a parameterized-width 2-flop synchronizer, reset to 0. It is instantiated once, for `row_in`.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_COUNT = 3.
- **Reset and scan:** release reset → `col_drive` = 0001, then 0010, 0100, 1000, 0001, each change one cycle after every 4th cycle. All other outputs are 0.
- **Clean press:** hold `row_in` = 0010 whenever `col_drive` = 0100 → a single `key_strobe` pulse, `row` = 0010, `col` = 0100, `key_pressed` = 1. The chained `keypad_decoder` with BASE = 16 reads 6 with valid = 1. `col_drive` stays at 0100.
- **Bounce:** `row_in` = 0010 matches on the first two ticks and is 0 on the third → no `key_strobe`, `key_pressed` stays 0, and scanning resumes at 1000.
- **Multi-key:** `row_in` = 0011 during column 0001 → ignored, and the scan continues.
- **Release:** from the clean-press held state, set `row_in` = 0 → after 3 ticks, a single `release_strobe` pulse, `row` = `col` = 0, `key_pressed` = 0, and `col_drive` advances to 1000. A single-tick release glitch instead returns to HELD with no strobe.
- **Reset mid-HELD:** assert `rst_n` = 0 for 1 cycle while held → the next cycle shows all outputs at their reset values and `col_drive` = 0001, with no `release_strobe`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} scan_state_t;

   localparam logic [3:0] COL0 = 4'b0001;
   localparam logic [3:0] COL1 = 4'b0010;
   localparam logic [3:0] COL2 = 4'b0100;
   localparam logic [3:0] COL3 = 4'b1000;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous keypad inputs, synchronous reset to 0.
module keypad_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner with press/release debouncing.
// Emits a registered one-hot {row, col} code plus press/release strobes.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_COUNT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_drive,
   output logic [3:0] row,
   output logic [3:0] col,
   output logic       key_pressed,
   output logic       key_strobe,
   output logic       release_strobe
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE_COUNT + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_COUNT);
   localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

   logic [3:0]       row_s;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [DB_W-1:0]  db_cnt;
   logic [DB_W-1:0]  db_inc;
   logic [3:0]       cand_row;
   logic [3:0]       cand_col;
   logic [3:0]       next_col;
   scan_state_t      state;

   keypad_sync #(.WIDTH(4)) u_row_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (row_in),
      .q     (row_s)
   );

   assign tick     = (div_cnt == DIV_LAST);
   assign db_inc   = db_cnt + DB_ONE;
   assign next_col = {col_drive[2:0], col_drive[3]};

   always_ff @(posedge clk) begin
      if (!rst_n)
         div_cnt <= '0;
      else
         div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
   end

   // Samples are taken only at the end of a slot so the strobed column has settled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= SCAN;
         col_drive      <= COL0;
         row            <= '0;
         col            <= '0;
         key_pressed    <= 1'b0;
         key_strobe     <= 1'b0;
         release_strobe <= 1'b0;
         cand_row       <= '0;
         cand_col       <= '0;
         db_cnt         <= '0;
      end else begin
         key_strobe     <= 1'b0;
         release_strobe <= 1'b0;
         if (tick) begin
            case (state)
               SCAN: begin
                  if (is_onehot4(row_s)) begin
                     cand_row <= row_s;
                     cand_col <= col_drive;
                     db_cnt   <= DB_ONE;
                     if (DEBOUNCE_COUNT == 1) begin
                        row         <= row_s;
                        col         <= col_drive;
                        key_pressed <= 1'b1;
                        key_strobe  <= 1'b1;
                        state       <= HELD;
                     end else begin
                        state <= PRESS_DB;
                     end
                  end else begin
                     col_drive <= next_col;
                  end
               end
               PRESS_DB: begin
                  if (row_s == cand_row) begin
                     db_cnt <= db_inc;
                     if (db_inc == DB_MAX) begin
                        row         <= cand_row;
                        col         <= cand_col;
                        key_pressed <= 1'b1;
                        key_strobe  <= 1'b1;
                        state       <= HELD;
                     end
                  end else begin
                     state     <= SCAN;
                     col_drive <= next_col;
                  end
               end
               HELD: begin
                  if (row_s != cand_row) begin
                     db_cnt <= DB_ONE;
                     if (DEBOUNCE_COUNT == 1) begin
                        row            <= '0;
                        col            <= '0;
                        key_pressed    <= 1'b0;
                        release_strobe <= 1'b1;
                        state          <= SCAN;
                        col_drive      <= next_col;
                     end else begin
                        state <= RELEASE_DB;
                     end
                  end
               end
               RELEASE_DB: begin
                  if (row_s != cand_row) begin
                     db_cnt <= db_inc;
                     if (db_inc == DB_MAX) begin
                        row            <= '0;
                        col            <= '0;
                        key_pressed    <= 1'b0;
                        release_strobe <= 1'b1;
                        state          <= SCAN;
                        col_drive      <= next_col;
                     end
                  end else begin
                     state <= HELD;
                  end
               end
               default: state <= SCAN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives row_in from col_drive,
// and a slot-level reference model predicts every output on every cycle.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DC = 3;

   localparam int M_IDLE  = 0;
   localparam int M_PRESS = 1;
   localparam int M_HOLD  = 2;
   localparam int M_REL   = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_drive, row, col;
   logic       key_pressed, key_strobe, release_strobe;

   logic [3:0] keys [4];   // keys[r][c] = 1 while that key is physically pressed

   int n_tests = 0;
   int n_fail  = 0;

   int         m_ci, m_mode, m_cnt;
   logic [3:0] m_cr;
   logic       m_ks, m_rs;

   always #5 clk = ~clk;

   always_comb begin
      row_in = '0;
      for (int r = 0; r < 4; r++) row_in[r] = |(keys[r] & col_drive);
   end

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_COUNT(DC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .row_in         (row_in),
      .col_drive      (col_drive),
      .row            (row),
      .col            (col),
      .key_pressed    (key_pressed),
      .key_strobe     (key_strobe),
      .release_strobe (release_strobe)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic bit m_pressed();
      return (m_mode == M_HOLD) || (m_mode == M_REL);
   endfunction

   task automatic clear_keys();
      for (int r = 0; r < 4; r++) keys[r] = '0;
   endtask

   task automatic model_reset();
      m_ci = 0; m_mode = M_IDLE; m_cnt = 0; m_cr = '0; m_ks = 1'b0; m_rs = 1'b0;
   endtask

   // One end-of-slot sample of the column currently strobed.
   task automatic model_tick();
      logic [3:0] s;
      for (int r = 0; r < 4; r++) s[r] = keys[r][m_ci];
      m_ks = 1'b0;
      m_rs = 1'b0;
      case (m_mode)
         M_IDLE:
            if ($countones(s) == 1) begin
               m_cr = s; m_cnt = 1; m_mode = M_PRESS;
               if (m_cnt == DC) begin m_mode = M_HOLD; m_ks = 1'b1; end
            end else m_ci = (m_ci + 1) % 4;
         M_PRESS:
            if (s == m_cr) begin
               m_cnt++;
               if (m_cnt == DC) begin m_mode = M_HOLD; m_ks = 1'b1; end
            end else begin
               m_mode = M_IDLE; m_ci = (m_ci + 1) % 4;
            end
         M_HOLD:
            if (s != m_cr) begin
               m_cnt = 1; m_mode = M_REL;
               if (m_cnt == DC) begin m_mode = M_IDLE; m_rs = 1'b1; m_ci = (m_ci + 1) % 4; end
            end
         default:
            if (s != m_cr) begin
               m_cnt++;
               if (m_cnt == DC) begin m_mode = M_IDLE; m_rs = 1'b1; m_ci = (m_ci + 1) % 4; end
            end else m_mode = M_HOLD;
      endcase
   endtask

   task automatic check_outs(input string tag);
      chk({tag, ".col_drive"}, col_drive, oh(m_ci));
      chk({tag, ".row"}, row, m_pressed() ? m_cr : 4'd0);
      chk({tag, ".col"}, col, m_pressed() ? oh(m_ci) : 4'd0);
      chk({tag, ".key_pressed"}, key_pressed, m_pressed());
      chk({tag, ".key_strobe"}, key_strobe, m_ks);
      chk({tag, ".release_strobe"}, release_strobe, m_rs);
   endtask

   // One full slot: three mid-slot cycles, then the tick cycle.
   task automatic step(input string tag);
      m_ks = 1'b0;
      m_rs = 1'b0;
      repeat (SD - 1) begin
         @(posedge clk); #1;
         check_outs({tag, ".mid"});
      end
      @(posedge clk); #1;
      model_tick();
      check_outs({tag, ".tick"});
   endtask

   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      clear_keys();
      repeat (ncyc) @(posedge clk);
      #1;
      model_reset();
      check_outs("reset");
      chk("reset.col_drive_const", col_drive, 4'b0001);
      chk("reset.no_release_strobe", release_strobe, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic wait_press(input string tag);
      for (int i = 0; i < 24 && !m_pressed(); i++) step(tag);
      chk({tag, ".press_seen"}, key_pressed, 1'b1);
   endtask

   initial begin
      logic [3:0] scan_seq [5];
      int dec;
      scan_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      clear_keys();
      model_reset();

      // Reset and free-running scan
      do_reset(3);
      for (int i = 0; i < 5; i++) begin
         step("scan");
         chk("scan.seq", col_drive, scan_seq[i]);
      end

      // Two keys in column 0 are ignored
      for (int i = 0; i < 8 && m_ci != 0; i++) step("align0");
      keys[0][0] = 1'b1; keys[1][0] = 1'b1;
      step("multi");
      chk("multi.key_pressed", key_pressed, 1'b0);
      chk("multi.col_drive", col_drive, 4'b0010);
      clear_keys();

      // Clean press of row 1 / column 2
      keys[1][2] = 1'b1;
      wait_press("press");
      chk("press.row", row, 4'b0010);
      chk("press.col", col, 4'b0100);
      dec = 0;
      for (int i = 0; i < 4; i++) begin
         if (row[i]) dec += 4 * i;
         if (col[i]) dec += i;
      end
      chk("press.decoder_code", dec, 6);
      step("held");
      step("held");
      chk("held.col_frozen", col_drive, 4'b0100);

      // Single-slot release glitch returns to held
      clear_keys();
      step("glitch");
      keys[1][2] = 1'b1;
      step("glitch_back");
      step("glitch_hold");
      chk("glitch.key_pressed", key_pressed, 1'b1);

      // Genuine release after three non-matching slots
      clear_keys();
      step("release");
      step("release");
      step("release");
      chk("release.key_pressed", key_pressed, 1'b0);
      chk("release.col_drive", col_drive, 4'b1000);

      // Bounce: two matches then a miss
      for (int i = 0; i < 8 && m_ci != 2; i++) step("align2");
      keys[1][2] = 1'b1;
      step("bounce");
      step("bounce");
      clear_keys();
      step("bounce_miss");
      chk("bounce.key_pressed", key_pressed, 1'b0);
      chk("bounce.col_drive", col_drive, 4'b1000);

      // Reset while held
      keys[1][2] = 1'b1;
      wait_press("press2");
      do_reset(1);
      step("post_reset");

      // Random key activity
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            int k;
            k = $urandom_range(0, 9);
            clear_keys();
            if (k >= 4) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            if (k >= 8) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
         end
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
